// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the push-button front end: repeat FSM states,
// default 75 MHz timing counts and channel index names.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } rpt_state_t;

  localparam int DEF_DEBOUNCE_CYC  = 750000;
  localparam int DEF_REPEAT_DELAY  = 22500000;
  localparam int DEF_REPEAT_PERIOD = 6000000;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, counter debounce, press/release strobes
// and an optional hold-to-repeat FSM.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic              s1_reg, s2_reg;
  logic              level_reg, level_next;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  rpt_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              press_reg, press_next;
  logic              release_reg, release_next;
  logic              repeat_reg, repeat_next;
  logic              rise, fall, tick;

  always_comb begin
    db_cnt_next = db_cnt_reg + 1'b1;
    level_next  = level_reg;
    rise        = 1'b0;
    fall        = 1'b0;
    if (s2_reg == level_reg) begin
      db_cnt_next = '0;
    end else if (db_cnt_reg == DB_LAST) begin
      db_cnt_next = '0;
      level_next  = s2_reg;
      rise        = s2_reg;
      fall        = ~s2_reg;
    end
  end

  // A release always wins over a repeat tick landing on the same edge.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg + 1'b1;
    tick          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        hold_cnt_next = '0;
        if (rise && REPEAT_EN) state_next = ST_DELAY;
      end
      ST_DELAY: begin
        if (fall) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == DELAY_LAST) begin
          tick          = 1'b1;
          hold_cnt_next = '0;
          state_next    = ST_RPT;
        end
      end
      ST_RPT: begin
        if (fall) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == PERIOD_LAST) begin
          tick          = 1'b1;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase
    press_next   = rise | tick;
    release_next = fall;
    repeat_next  = tick;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      level_reg    <= 1'b0;
      db_cnt_reg   <= '0;
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      repeat_reg   <= 1'b0;
    end else begin
      s1_reg       <= btn_in;
      s2_reg       <= s1_reg;
      level_reg    <= level_next;
      db_cnt_reg   <= db_cnt_next;
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      repeat_reg   <= repeat_next;
    end
  end

  assign btn_level   = level_reg;
  assign btn_press   = press_reg;
  assign btn_release = release_reg;
  assign btn_repeat  = repeat_reg;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button front end for the game controls; each bit of REPEAT_MASK
// enables hold-to-repeat on the matching channel.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int               N_BTN         = 4,
  parameter int               DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int               REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(4'b1011)
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  generate
    if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_err
      $error("btn_conditioner: DEBOUNCE_CYC>=1, REPEAT_DELAY>=2, REPEAT_PERIOD>=2 required");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .REPEAT_EN     (REPEAT_MASK[gi])
      ) u_chan (
        .pclk        (pclk),
        .rst         (rst),
        .btn_in      (btn_in[gi]),
        .btn_level   (btn_level[gi]),
        .btn_press   (btn_press[gi]),
        .btn_release (btn_release[gi]),
        .btn_repeat  (btn_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner against a window/timestamp model.
module tb_btn_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam logic [N-1:0] MASK = 4'b1011;
  localparam int L  = DB + 2;

  logic         pclk = 1'b0;
  logic         rst  = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  always #5 pclk = ~pclk;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .pclk(pclk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: the level flips when the last DB synchronised samples (inputs taken
  // 2..DB+1 edges ago) all disagree with it; repeats fall at press+RD+k*RP.
  bit           hist [N][L];
  bit           m_level [N];
  bit           m_held [N];
  int           t_press [N];
  logic [N-1:0] exp_level = '0, exp_press = '0, exp_release = '0, exp_repeat = '0;

  task automatic model_step();
    bit all_diff, rise, fall, tick;
    int d;
    cyc++;
    for (int ch = 0; ch < N; ch++) begin
      if (rst) begin
        for (int i = 0; i < L; i++) hist[ch][i] = 1'b0;
        m_level[ch] = 1'b0;
        m_held[ch]  = 1'b0;
        exp_level[ch] = 1'b0; exp_press[ch] = 1'b0;
        exp_release[ch] = 1'b0; exp_repeat[ch] = 1'b0;
      end else begin
        for (int i = 0; i < L - 1; i++) hist[ch][i] = hist[ch][i+1];
        hist[ch][L-1] = btn_in[ch];
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[ch][i] == m_level[ch]) all_diff = 1'b0;
        rise = all_diff && !m_level[ch];
        fall = all_diff && m_level[ch];
        tick = 1'b0;
        if (m_held[ch] && !fall) begin
          d = cyc - t_press[ch];
          if (d >= RD && (d - RD) % RP == 0) tick = 1'b1;
        end
        if (rise) begin
          m_level[ch] = 1'b1;
          if (MASK[ch]) begin
            m_held[ch]  = 1'b1;
            t_press[ch] = cyc;
          end
        end
        if (fall) begin
          m_level[ch] = 1'b0;
          m_held[ch]  = 1'b0;
        end
        exp_level[ch]   = m_level[ch];
        exp_press[ch]   = rise | tick;
        exp_release[ch] = fall;
        exp_repeat[ch]  = tick;
      end
    end
  endtask

  always @(posedge pclk) model_step();

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("level",   btn_level,   exp_level);
      chk("press",   btn_press,   exp_press);
      chk("release", btn_release, exp_release);
      chk("repeat",  btn_repeat,  exp_repeat);
    end
  end

  int rem [N];
  int rst_left;
  int r;

  initial begin
    rst = 1'b1;
    btn_in = '0;
    repeat (3) @(negedge pclk);
    chk_en = 1'b1;
    chk("rst_level", btn_level, 4'b0000);
    chk("rst_press", btn_press, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge pclk);

    // ch0 and ch2 rise together; only ch0 repeats
    btn_in = 4'b0101;
    repeat (5) @(negedge pclk);
    chk("t1_press_early", btn_press, 4'b0000);
    @(negedge pclk);
    chk("t1_press", btn_press, 4'b0101);
    chk("t1_level", btn_level, 4'b0101);
    @(negedge pclk);
    chk("t1_press_1cyc", btn_press, 4'b0000);
    repeat (9) @(negedge pclk);
    chk("t1_first_repeat", btn_repeat, 4'b0001);
    chk("t1_first_rpt_press", btn_press, 4'b0001);
    @(negedge pclk);
    chk("t1_repeat_1cyc", btn_repeat, 4'b0000);
    repeat (4) @(negedge pclk);
    chk("t1_second_repeat", btn_repeat, 4'b0001);
    btn_in = 4'b0000;
    repeat (6) @(negedge pclk);
    chk("t1_release", btn_release, 4'b0101);
    chk("t1_no_rpt_at_release", btn_repeat, 4'b0000);
    repeat (4) @(negedge pclk);

    // 3-cycle glitch on ch1 is swallowed
    btn_in = 4'b0010;
    repeat (3) @(negedge pclk);
    btn_in = 4'b0000;
    repeat (8) @(negedge pclk);
    chk("t2_glitch_level", btn_level, 4'b0000);

    // bounce 1,0,1 then steady on ch1
    btn_in = 4'b0010; repeat (2) @(negedge pclk);
    btn_in = 4'b0000; repeat (2) @(negedge pclk);
    btn_in = 4'b0010;
    repeat (5) @(negedge pclk);
    chk("t3_press_early", btn_press, 4'b0000);
    @(negedge pclk);
    chk("t3_press", btn_press, 4'b0010);
    btn_in = 4'b0000;
    repeat (10) @(negedge pclk);

    // ch3 held 40 cycles: fall edge coincides with a would-be repeat
    btn_in = 4'b1000;
    repeat (6) @(negedge pclk);
    chk("t4_press", btn_press, 4'b1000);
    repeat (34) @(negedge pclk);
    btn_in = 4'b0000;
    @(negedge pclk);
    chk("t4_repeat", btn_repeat, 4'b1000);
    repeat (5) @(negedge pclk);
    chk("t4_release", btn_release, 4'b1000);
    chk("t4_no_repeat", btn_repeat, 4'b0000);
    repeat (4) @(negedge pclk);

    // reset while repeating with the button still held
    btn_in = 4'b1000;
    repeat (20) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    chk("t5_rst_level", btn_level, 4'b0000);
    @(negedge pclk);
    chk("t5_rst_press", btn_press, 4'b0000);
    rst = 1'b0;
    repeat (5) @(negedge pclk);
    chk("t5_press_early", btn_press, 4'b0000);
    @(negedge pclk);
    chk("t5_press", btn_press, 4'b1000);
    repeat (10) @(negedge pclk);
    chk("t5_repeat", btn_repeat, 4'b1000);
    btn_in = 4'b0000;
    repeat (10) @(negedge pclk);

    // simultaneous rise on ch0 and ch3
    btn_in = 4'b1001;
    repeat (6) @(negedge pclk);
    chk("t6_press", btn_press, 4'b1001);
    repeat (3) @(negedge pclk);
    btn_in = 4'b0000;
    repeat (12) @(negedge pclk);

    // random segments of glitches, short and long holds, rare resets
    for (int ch = 0; ch < N; ch++) rem[ch] = 0;
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          btn_in[ch] = ~btn_in[ch];
          r = $urandom_range(0, 9);
          if (r < 3)      rem[ch] = $urandom_range(1, 3);
          else if (r < 7) rem[ch] = $urandom_range(4, 12);
          else            rem[ch] = $urandom_range(15, 40);
        end
        rem[ch]--;
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
      rst = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      @(negedge pclk);
    end
    rst = 1'b0;
    btn_in = '0;
    repeat (10) @(negedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
